// File: rtl/muldiv_unit_if.sv
// Request/writeback bundle for the iterative multiply/divide unit.
interface muldiv_unit_if #(parameter int WORD_SIZE = 32);
  logic                 start;
  logic [2:0]           funct3;
  logic [WORD_SIZE-1:0] op_a;
  logic [WORD_SIZE-1:0] op_b;
  logic [4:0]           rd_in;
  logic                 flush;
  logic                 busy;
  logic                 done;
  logic                 wb_en;
  logic [4:0]           wb_rd;
  logic [WORD_SIZE-1:0] wb_data;

  modport master (
    output start, funct3, op_a, op_b, rd_in, flush,
    input  busy, done, wb_en, wb_rd, wb_data
  );

  modport slave (
    input  start, funct3, op_a, op_b, rd_in, flush,
    output busy, done, wb_en, wb_rd, wb_data
  );
endinterface

// File: rtl/muldiv_unit.sv
// Fixed-latency RV32M multiply/divide unit: one shift-add or restoring
// shift-subtract step per clock on operand magnitudes, sign fixed at the end.
module muldiv_unit #(
  parameter int WORD_SIZE = 32
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);
  localparam int W  = WORD_SIZE;
  localparam int CW = $clog2(WORD_SIZE);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    op;
  logic [4:0]    rd;
  logic [W-1:0]  opnd;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          neg;

  logic          sa, sb, neg_in;
  logic [W-1:0]  mag_a, mag_b;

  always_comb begin
    sa    = bus.op_a[W-1] & (bus.funct3 inside {3'd1, 3'd2, 3'd4, 3'd6});
    sb    = bus.op_b[W-1] & (bus.funct3 inside {3'd1, 3'd4, 3'd6});
    mag_a = sa ? -bus.op_a : bus.op_a;
    mag_b = sb ? -bus.op_b : bus.op_b;
    // Signed divide by zero must yield all-ones, so the quotient keeps its raw magnitude.
    case (bus.funct3)
      3'd4:    neg_in = (sa ^ sb) & (bus.op_b != '0);
      3'd6:    neg_in = sa;
      default: neg_in = sa ^ sb;
    endcase
  end

  logic [W:0]     mul_sum, div_sh, div_diff;
  logic [W-1:0]   nhi, nlo;
  logic [2*W-1:0] prod, prod_s;
  logic [W-1:0]   qr, qr_s, result;

  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    div_sh   = {hi, lo[W-1]};
    div_diff = div_sh - {1'b0, opnd};
    if (op[2]) begin
      if (!div_diff[W]) begin
        nhi = div_diff[W-1:0];
        nlo = {lo[W-2:0], 1'b1};
      end else begin
        nhi = div_sh[W-1:0];
        nlo = {lo[W-2:0], 1'b0};
      end
    end else begin
      nhi = mul_sum[W:1];
      nlo = {mul_sum[0], lo[W-1:1]};
    end
    prod   = {nhi, nlo};
    prod_s = neg ? -prod : prod;
    qr     = op[1] ? nhi : nlo;
    qr_s   = neg ? -qr : qr;
    if (op[2])                result = qr_s;
    else if (op[1:0] == 2'd0) result = prod_s[W-1:0];
    else                      result = prod_s[2*W-1:W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      op          <= '0;
      rd          <= '0;
      opnd        <= '0;
      hi          <= '0;
      lo          <= '0;
      neg         <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.wb_en   <= 1'b0;
      bus.wb_rd   <= '0;
      bus.wb_data <= '0;
    end else begin
      bus.done    <= 1'b0;
      bus.wb_en   <= 1'b0;
      bus.wb_rd   <= '0;
      bus.wb_data <= '0;
      case (state)
        // DONE doubles as an accept slot so a held start issues back-to-back.
        IDLE, DONE: begin
          if (bus.start && !bus.flush) begin
            state    <= CALC;
            bus.busy <= 1'b1;
            cnt      <= '0;
            op       <= bus.funct3;
            rd       <= bus.rd_in;
            neg      <= neg_in;
            hi       <= '0;
            opnd     <= bus.funct3[2] ? mag_b : mag_a;
            lo       <= bus.funct3[2] ? mag_a : mag_b;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        CALC: begin
          if (bus.flush) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            hi  <= nhi;
            lo  <= nlo;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(W - 1)) begin
              state       <= DONE;
              bus.done    <= 1'b1;
              bus.wb_en   <= (rd != '0);
              bus.wb_rd   <= rd;
              bus.wb_data <= result;
            end
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases plus random ops
// checked against a plain-arithmetic RV32M model.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  muldiv_unit_if #(.WORD_SIZE(32)) bus ();

  muldiv_unit #(.WORD_SIZE(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        en;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa, sbv, sp;
    logic [63:0]        ua, ub, up;
    logic               ovf;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin up = ua * ub; return up[31:0]; end
      3'd1: begin sp = sa * sbv; return sp[63:32]; end
      3'd2: begin sp = sa * $signed(ub); return sp[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        sp = sa / sbv;
        return sp[31:0];
      end
      3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'h0) return a;
        if (ovf) return 32'h0;
        sp = sa % sbv;
        return sp[31:0];
      end
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Called at a negedge; the accepting edge is the next posedge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_data, input bit expect_done);
    exp_t e;
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.rd_in  = rd;
    if (expect_done) begin
      e.due  = cyc + 33;
      e.rd   = rd;
      e.data = exp_data;
      e.en   = (rd != 5'd0);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL done_timeout actual=no_done required=done (cycle %0d)", cyc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.done) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done actual=done required=no_done wb_rd=%0d wb_data=%h (cycle %0d)",
                 bus.wb_rd, bus.wb_data, cyc);
      end else begin
        e = sb.pop_front();
        chk("wb_data", 64'(bus.wb_data), 64'(e.data));
        chk("wb_rd", 64'(bus.wb_rd), 64'(e.rd));
        chk("wb_en", 64'(bus.wb_en), 64'(e.en));
        chk("latency", 64'(cyc), 64'(e.due));
      end
    end else begin
      chk("idle_outputs", {25'h0, bus.wb_en, bus.wb_rd, bus.wb_data}, 64'h0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  logic [2:0]  d_f[8]   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4};
  logic [31:0] d_a[8]   = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                            32'hFFFF_FFF9, 32'd5, 32'd5, 32'h8000_0000};
  logic [31:0] d_b[8]   = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                            32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF};
  logic [31:0] d_exp[8] = '{32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000};

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [4:0]  rd;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = '0;
    bus.op_a   = '0;
    bus.op_b   = '0;
    bus.rd_in  = '0;

    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Basic MUL with exact timing of busy.
    issue(3'd0, 32'd7, 32'd6, 5'd5, 32'd42, 1'b1);
    chk("busy_after_start", 64'(bus.busy), 64'd1);
    wait_done();
    @(negedge clk);
    chk("busy_after_done", 64'(bus.busy), 64'd0);

    // Corner vectors, issued back-to-back from the done cycle.
    for (int i = 0; i < 8; i++) begin
      issue(d_f[i], d_a[i], d_b[i], 5'(i + 1), d_exp[i], 1'b1);
      wait_done();
    end
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h0, 1'b1);
    wait_done();
    @(negedge clk);

    // A second start mid-operation must not disturb the first.
    issue(3'd0, 32'd3, 32'd4, 5'd10, 32'd12, 1'b1);
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    bus.op_a  = 32'd100;
    bus.op_b  = 32'd100;
    bus.rd_in = 5'd11;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done();
    @(negedge clk);
    chk("busy_after_ignored_start", 64'(bus.busy), 64'd0);

    // Flush mid-operation.
    issue(3'd5, 32'd1000, 32'd7, 5'd12, 32'd0, 1'b0);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    chk("busy_after_flush", 64'(bus.busy), 64'd0);
    repeat (30) @(negedge clk);

    // Start together with flush in IDLE is dropped.
    bus.start = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("busy_start_flush_idle", 64'(bus.busy), 64'd0);
    repeat (35) @(negedge clk);

    // Asynchronous reset mid-operation.
    issue(3'd0, 32'd9, 32'd9, 5'd13, 32'd0, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("busy_async_reset", 64'(bus.busy), 64'd0);
    chk("done_async_reset", 64'(bus.done), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("busy_after_reset_release", 64'(bus.busy), 64'd0);

    // rd=0 completes without a write.
    issue(3'd4, 32'd100, 32'd7, 5'd0, 32'd14, 1'b1);
    wait_done();

    for (int n = 0; n < 150; n++) begin
      f  = 3'($urandom_range(0, 7));
      a  = rnd_operand();
      b  = rnd_operand();
      rd = 5'($urandom_range(0, 31));
      issue(f, a, b, rd, ref_model(f, a, b), 1'b1);
      wait_done();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1, request; sampled only in IDLE.
REQ-005 SHALL have port funct3, input, 3, op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 SHALL have port op_a, input, WORD_SIZE, operand A (from register file rv1).
REQ-007 SHALL have port op_b, input, WORD_SIZE, operand B (from register file rv2).
REQ-008 SHALL have port rd_in, input, 5, destination register index.
REQ-009 SHALL have port flush, input, 1, synchronous abort of the in-flight op.
REQ-010 SHALL have port busy, output, 1, high in CALC and DONE.
REQ-011 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port wb_en, output, 1, register file write enable.
REQ-013 SHALL have port wb_rd, output, 5, register file write index.
REQ-014 SHALL have port wb_data, output, WORD_SIZE, register file write data.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE.
REQ-016 IDLE: start=1 and flush=0 at edge T SHALL latch funct3, op_a, op_b, rd_in, clear iteration counter, go to CALC.
REQ-017 CALC SHALL perform one iteration per edge: shift-add for multiply, restoring shift-subtract for divide, on operand magnitudes.
REQ-018 After 32 iterations (edge T+32) the FSM SHALL enter DONE; DONE SHALL last exactly one cycle, then return to IDLE at T+33.
REQ-019 Latency SHALL be fixed at 32 cycles for all ops and operand values, including special cases.
REQ-020 In DONE: done=1, wb_rd=latched rd, wb_data=result; wb_en=1 only if latched rd!=0.
REQ-021 Outside DONE: done=0, wb_en=0, wb_rd=0, wb_data=0.
REQ-022 MUL SHALL return product bits [31:0]; MULH, MULHSU, MULHU bits [63:32] of the 64-bit signed*signed, signed*unsigned, unsigned*unsigned product.
REQ-023 Signed ops SHALL negate the magnitude result when operand signs differ (quotient, product) or dividend negative (remainder).
REQ-024 Divide by zero: DIV/DIVU SHALL return 0xFFFFFFFF; REM/REMU SHALL return op_a.
REQ-025 Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF): DIV SHALL return 0x80000000; REM SHALL return 0.
REQ-026 start while busy=1 SHALL be ignored with no effect on the in-flight op.
REQ-027 flush=1 in CALC or DONE SHALL force IDLE at the next edge; no done/wb_en pulse after that edge.
REQ-028 flush and start both high in IDLE SHALL leave the FSM in IDLE.
REQ-029 start held high SHALL allow back-to-back ops: a new op SHALL be accepted at edge T+33.

Reset
REQ-030 rst=0 SHALL immediately, regardless of clk, force IDLE and clear counter, operand/accumulator registers and latched rd.
REQ-031 During and after reset: busy=0, done=0, wb_en=0, wb_rd=0, wb_data=0.
REQ-032 Reset mid-operation SHALL discard the op; no write issued after rst release.

Verification
REQ-033 MUL op_a=7, op_b=6, rd_in=5 at T -> busy 1 from T; T+32: done=1, wb_en=1, wb_rd=5, wb_data=42; T+33: busy=0.
REQ-034 MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE.
REQ-035 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; all at T+32.
REQ-036 Second start at T+10 with different operands -> ignored; first result unchanged at T+32.
REQ-037 flush at T+10 -> IDLE and busy=0 after T+11; no done or wb_en through T+40.
REQ-038 rst low at T+5 -> busy=0 immediately; no wb_en after release. Separately, op with rd_in=0 -> done=1 with wb_en=0 at T+32.
